// File: rtl/seg7_bcd_scan.sv
// ---------------------------------------------------------------------------
// seg7_bcd_scan
//   Four-digit multiplexed seven-segment driver. A prescaler sets how many
//   clocks each digit slot lasts; a 2-bit index walks ones -> thousands. The
//   four BCD digits and the blanking enable are captured once per frame into
//   a shadow register so a frame never shows a mix of old and new values.
//
// Ports
//   clk            system clock, rising edge
//   rst            asynchronous active-high reset
//   bcd_thousands  most significant BCD digit
//   bcd_hundreds   hundreds digit
//   bcd_tens       tens digit
//   bcd_ones       least significant digit
//   blank_lz       1 = blank leading zeros (captured with the digits)
//   an             active-low anode enables, an[0]=ones .. an[3]=thousands
//   seg            active-low cathodes, seg[6:0] = g,f,e,d,c,b,a
//   frame_start    one-cycle pulse the cycle after a new frame is captured
// ---------------------------------------------------------------------------
module seg7_bcd_scan #(
  parameter int unsigned REFRESH_DIV = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] bcd_thousands,
  input  logic [3:0] bcd_hundreds,
  input  logic [3:0] bcd_tens,
  input  logic [3:0] bcd_ones,
  input  logic       blank_lz,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       frame_start
);

  localparam int unsigned CNT_W = $clog2(REFRESH_DIV);

  typedef struct packed {
    logic [3:0] thousands;
    logic [3:0] hundreds;
    logic [3:0] tens;
    logic [3:0] ones;
    logic       blank_lz;
  } shadow_t;

  logic [CNT_W-1:0] cnt;
  logic [1:0]       idx;
  shadow_t          shadow;

  logic             tick;
  logic             frame_tick;
  logic [3:0]       digit;
  logic             blank;
  logic [3:0]       an_next;
  logic [6:0]       seg_next;

  // Active-low segment pattern; anything above 9 renders as a dash.
  function automatic logic [6:0] seg_code(input logic [3:0] d);
    case (d)
      4'd0:    seg_code = 7'h40;
      4'd1:    seg_code = 7'h79;
      4'd2:    seg_code = 7'h24;
      4'd3:    seg_code = 7'h30;
      4'd4:    seg_code = 7'h19;
      4'd5:    seg_code = 7'h12;
      4'd6:    seg_code = 7'h02;
      4'd7:    seg_code = 7'h78;
      4'd8:    seg_code = 7'h00;
      4'd9:    seg_code = 7'h10;
      default: seg_code = 7'h3F;
    endcase
  endfunction

  assign tick       = (cnt == CNT_W'(REFRESH_DIV - 1));
  // The last tick of the thousands slot is the frame boundary.
  assign frame_tick = tick && (idx == 2'd3);

  // Slot decode from the current index and shadow; registered below, so the
  // pins lag the index by one clock.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    digit = shadow.ones;
    blank = 1'b0;
    case (idx)
      2'd0: begin
        digit = shadow.ones;
        blank = 1'b0;
      end
      2'd1: begin
        digit = shadow.tens;
        blank = shadow.blank_lz && (shadow.thousands == 4'd0) &&
                (shadow.hundreds == 4'd0) && (shadow.tens == 4'd0);
      end
      2'd2: begin
        digit = shadow.hundreds;
        blank = shadow.blank_lz && (shadow.thousands == 4'd0) &&
                (shadow.hundreds == 4'd0);
      end
      default: begin
        digit = shadow.thousands;
        blank = shadow.blank_lz && (shadow.thousands == 4'd0);
      end
    endcase

    an_next  = blank ? 4'hF : ~(4'b0001 << idx);
    seg_next = blank ? 7'h7F : seg_code(digit);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt         <= '0;
      idx         <= 2'd0;
      shadow      <= '0;
      frame_start <= 1'b0;
      an          <= 4'hF;
      seg         <= 7'h7F;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      if (tick) begin
        cnt <= '0;
        idx <= idx + 2'd1;
      end else begin
        cnt <= cnt + 1'b1;
      end

      if (frame_tick) begin
        shadow <= '{thousands: bcd_thousands, hundreds: bcd_hundreds,
                    tens: bcd_tens, ones: bcd_ones, blank_lz: blank_lz};
      end

      frame_start <= frame_tick;
      an          <= an_next;
      seg         <= seg_next;
    end
  end

endmodule

// File: tb/tb_seg7_bcd_scan.sv
// ---------------------------------------------------------------------------
// tb_seg7_bcd_scan
//   Scoreboard bench for seg7_bcd_scan with REFRESH_DIV=4 (16-cycle frame).
//   The stimulus process drives directed input sets and queues the expected
//   {an, seg, frame_start} for every upcoming cycle; the monitor pops one
//   entry per falling edge and compares it with the DUT outputs.
// ---------------------------------------------------------------------------
module tb_seg7_bcd_scan;

  localparam int unsigned DIV = 4;

  logic       clk;
  logic       rst;
  logic [3:0] bcd_thousands, bcd_hundreds, bcd_tens, bcd_ones;
  logic       blank_lz;
  logic [3:0] an;
  logic [6:0] seg;
  logic       frame_start;

  typedef struct {
    string      name;
    logic [3:0] an;
    logic [6:0] seg;
    logic       fs;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  // Lit anode pattern per slot (ones .. thousands).
  logic [3:0] an_lit [4] = '{4'hE, 4'hD, 4'hB, 4'h7};

  seg7_bcd_scan #(.REFRESH_DIV(DIV)) dut (
    .clk           (clk),
    .rst           (rst),
    .bcd_thousands (bcd_thousands),
    .bcd_hundreds  (bcd_hundreds),
    .bcd_tens      (bcd_tens),
    .bcd_ones      (bcd_ones),
    .blank_lz      (blank_lz),
    .an            (an),
    .seg           (seg),
    .frame_start   (frame_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [11:0] act,
                       input logic [11:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got {an,seg,fs}=%h required %h", name, act, req);
    end
  endtask

  task automatic push(input string name, input logic [3:0] a,
                      input logic [6:0] s, input logic fs);
    exp_t e;
    e.name = name;
    e.an   = a;
    e.seg  = s;
    e.fs   = fs;
    exp_q.push_back(e);
  endtask

  // Queue n cycles of a frame: slot k/DIV shows segs[slot] if lit[slot],
  // otherwise blank; frame_start is expected on the 16th cycle only.
  task automatic push_frame(input string nm, input logic [6:0] s0,
                            input logic [6:0] s1, input logic [6:0] s2,
                            input logic [6:0] s3, input logic [3:0] lit,
                            input int n);
    logic [6:0] segs [4];
    segs = '{s0, s1, s2, s3};
    for (int k = 0; k < n; k++) begin
      int sl;
      sl = k / DIV;
      push($sformatf("%s_c%0d", nm, k),
           lit[sl] ? an_lit[sl] : 4'hF,
           lit[sl] ? segs[sl] : 7'h7F,
           k == 4 * DIV - 1);
    end
  endtask

  task automatic set_in(input logic [3:0] th, input logic [3:0] hu,
                        input logic [3:0] te, input logic [3:0] on,
                        input logic blz);
    bcd_thousands = th;
    bcd_hundreds  = hu;
    bcd_tens      = te;
    bcd_ones      = on;
    blank_lz      = blz;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: one comparison per falling edge while expectations are queued.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check(e.name, {an, seg, frame_start}, {e.an, e.seg, e.fs});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, queue=%0d", exp_q.size());
    $fatal(1, "watchdog");
  end

  // Stimulus. P0 is the edge at which reset is released; frame contents are
  // captured at P16, P32, ... and shown on the 16 following cycles.
  initial begin
    rst = 1'b1;
    set_in(4'd2, 4'd0, 4'd4, 4'd7, 1'b0);
    push("reset_hold", 4'hF, 7'h7F, 1'b0);
    step(3);
    rst = 1'b0;
    push("after_release", 4'hF, 7'h7F, 1'b0);
    // First frame comes from the zeroed shadow: every slot shows "0".
    push_frame("frame1_zero", 7'h40, 7'h40, 7'h40, 7'h40, 4'hF, 16);
    push_frame("f2_2047",     7'h78, 7'h19, 7'h40, 7'h24, 4'hF, 16);

    step(16);   // P16+1
    set_in(4'd0, 4'd0, 4'd4, 4'd2, 1'b1);
    push_frame("f3_0042_blz", 7'h24, 7'h19, 7'h7F, 7'h7F, 4'b0011, 16);

    step(16);   // P32+1
    set_in(4'd0, 4'd0, 4'd0, 4'd0, 1'b1);
    push_frame("f4_0000_blz", 7'h40, 7'h7F, 7'h7F, 7'h7F, 4'b0001, 16);

    step(16);   // P48+1
    set_in(4'd0, 4'd0, 4'hA, 4'd5, 1'b1);
    push_frame("f5_00A5_blz", 7'h12, 7'h3F, 7'h7F, 7'h7F, 4'b0011, 16);

    step(16);   // P64+1
    set_in(4'd0, 4'd1, 4'd2, 4'd3, 1'b0);
    push_frame("f6_0123", 7'h30, 7'h24, 7'h79, 7'h40, 4'hF, 16);

    step(20);   // P84+1: frame 6 is in its tens slot
    set_in(4'd0, 4'd9, 4'd9, 4'd9, 1'b0);
    push_frame("f7_0999", 7'h10, 7'h10, 7'h10, 7'h40, 4'hF, 16);
    // Frame 8 is cut short by reset once the hundreds slot begins.
    push_frame("f8_part", 7'h10, 7'h10, 7'h10, 7'h40, 4'hF, 8);

    step(37);   // P121+1: index is 2
    rst = 1'b1;
    push("reset_mid", 4'hF, 7'h7F, 1'b0);

    step(1);    // P122+1
    rst = 1'b0;
    set_in(4'd2, 4'd0, 4'd4, 4'd7, 1'b1);
    push("after_release2", 4'hF, 7'h7F, 1'b0);
    push_frame("restart_zero", 7'h40, 7'h40, 7'h40, 7'h40, 4'hF, 16);
    // Hundreds is 0 but thousands is not, so nothing is blanked.
    push_frame("f_2047_blz", 7'h78, 7'h19, 7'h40, 7'h24, 4'hF, 16);

    for (int i = 0; i < 200 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) check("drain", 12'(exp_q.size()), 12'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
